// File: rtl/ysyx_23060072_bus_arbiter_pkg.sv
// Shared encodings and widths for the IFU/LSU memory-port arbiter.
// Optional round-robin arbitration is enabled with YSYX_23060072_ARB_RR_EN.
package ysyx_23060072_bus_arbiter_pkg;

  localparam int unsigned ARB_ADDR_W = 32;
  localparam int unsigned ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic OWNER_IF  = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

  localparam logic ARB_ENABLE  = 1'b1;
  localparam logic ARB_DISABLE = 1'b0;

endpackage

// File: rtl/ysyx_23060072_arb_pick.sv
// Combinational winner selector for the arbiter's IDLE state.
// YSYX_23060072_ARB_RR_EN selects round-robin; otherwise LSU has fixed priority.
module ysyx_23060072_arb_pick
  import ysyx_23060072_bus_arbiter_pkg::*;
(
  input  logic if_valid,
  input  logic lsu_valid,
  input  logic flush_i,
  input  logic last_owner,
  output logic grant_if,
  output logic grant_lsu
);

  // A fetch is never accepted while the pipeline is being flushed.
  logic if_elig;
  assign if_elig = if_valid & ~flush_i;

`ifdef YSYX_23060072_ARB_RR_EN
  assign grant_lsu = lsu_valid & (~if_elig | (last_owner == OWNER_IF));
  assign grant_if  = if_elig & (~lsu_valid | (last_owner == OWNER_LSU));
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
  assign grant_lsu = lsu_valid;
  assign grant_if  = if_elig & ~lsu_valid;
`endif

endmodule

// File: rtl/ysyx_23060072_bus_arbiter.sv
// Two-master (IFU/LSU) arbiter for the single core memory port, one transaction in flight.
// Round-robin selection is enabled with YSYX_23060072_ARB_RR_EN.
module ysyx_23060072_bus_arbiter
  import ysyx_23060072_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ARB_ADDR_W,
  parameter int unsigned DATA_W = ARB_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  input  logic                if_req_valid_i,
  output logic                if_req_ready_o,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_resp_valid_o,
  input  logic                if_resp_ready_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_resp_err_o,
  input  logic                lsu_req_valid_i,
  output logic                lsu_req_ready_o,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic                lsu_wen_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  input  logic [DATA_W/8-1:0] lsu_wstrb_i,
  output logic                lsu_resp_valid_o,
  input  logic                lsu_resp_ready_i,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  output logic                lsu_resp_err_o,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                mem_wen_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  input  logic                mem_resp_valid_i,
  output logic                mem_resp_ready_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_resp_err_i,
  output logic                busy_o
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_t;

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       drop_q, drop_d;
  logic       drop_now;
  req_t       req_q, req_d;
  logic       grant_if, grant_lsu;
  logic       last_owner;

`ifdef YSYX_23060072_ARB_RR_EN
  logic last_owner_q, last_owner_d;

  // Remember who was served last so a contended IDLE alternates.
  always_comb begin
    last_owner_d = last_owner_q;
    if (state_q == IDLE && (grant_if || grant_lsu)) begin
      last_owner_d = grant_lsu ? OWNER_LSU : OWNER_IF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) last_owner_q <= OWNER_IF;
    else        last_owner_q <= last_owner_d;
  end

  assign last_owner = last_owner_q;
`else
  assign last_owner = OWNER_IF;
`endif

  ysyx_23060072_arb_pick u_pick (
    .if_valid   (if_req_valid_i),
    .lsu_valid  (lsu_req_valid_i),
    .flush_i    (flush_i),
    .last_owner (last_owner),
    .grant_if   (grant_if),
    .grant_lsu  (grant_lsu)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWNER_IF;
      drop_q  <= 1'b0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      drop_q  <= drop_d;
      req_q   <= req_d;
    end
  end

  assign mem_addr_o  = req_q.addr;
  assign mem_wen_o   = req_q.wen;
  assign mem_wdata_o = req_q.wdata;
  assign mem_wstrb_o = req_q.wstrb;
  assign busy_o      = (state_q != IDLE);

  // Next-state and handshake outputs; response path is a passthrough to the owner.
  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    drop_d           = drop_q;
    req_d            = req_q;
    drop_now         = drop_q | (flush_i & (owner_q == OWNER_IF));
    if_req_ready_o   = 1'b0;
    lsu_req_ready_o  = 1'b0;
    mem_req_valid_o  = 1'b0;
    mem_resp_ready_o = 1'b0;
    if_resp_valid_o  = 1'b0;
    if_rdata_o       = '0;
    if_resp_err_o    = 1'b0;
    lsu_resp_valid_o = 1'b0;
    lsu_rdata_o      = '0;
    lsu_resp_err_o   = 1'b0;

    case (state_q)
      IDLE: begin
        if_req_ready_o  = grant_if;
        lsu_req_ready_o = grant_lsu;
        if (grant_lsu) begin
          owner_d = OWNER_LSU;
          req_d   = '{addr: lsu_addr_i, wen: lsu_wen_i, wdata: lsu_wdata_i, wstrb: lsu_wstrb_i};
          state_d = REQ;
        end else if (grant_if) begin
          owner_d = OWNER_IF;
          req_d   = '{addr: if_addr_i, wen: ARB_DISABLE, wdata: '0, wstrb: '0};
          state_d = REQ;
        end
      end
      REQ: begin
        mem_req_valid_o = 1'b1;
        drop_d          = drop_now;
        if (mem_req_ready_i) state_d = RESP;
      end
      RESP: begin
        drop_d = drop_now;
        if (owner_q == OWNER_LSU) begin
          lsu_resp_valid_o = mem_resp_valid_i;
          mem_resp_ready_o = lsu_resp_ready_i;
          lsu_rdata_o      = mem_rdata_i;
          lsu_resp_err_o   = mem_resp_err_i;
        end else begin
          // A flushed fetch is drained silently from the downstream.
          if_resp_valid_o  = mem_resp_valid_i & ~drop_now;
          mem_resp_ready_o = drop_now | if_resp_ready_i;
          if_rdata_o       = mem_rdata_i;
          if_resp_err_o    = mem_resp_err_i;
        end
        if (mem_resp_valid_i && mem_resp_ready_o) begin
          state_d = IDLE;
          drop_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!rst_n) begin
      if_req_ready_o   = 1'b0;
      lsu_req_ready_o  = 1'b0;
      mem_req_valid_o  = 1'b0;
      mem_resp_ready_o = 1'b0;
      if_resp_valid_o  = 1'b0;
      lsu_resp_valid_o = 1'b0;
    end
  end

endmodule
